pc_redirect_unit: RTL
=====================

// Module: pc_redirect_unit
// PURPOSE
//   Program-counter register plus next-PC selection for the multicycle core, with a
//   parametrised return-address stack (RAS) that predicts JALR return targets.
//   Sits between the ALU result paths and the instruction-fetch address; driven by the
//   control FSM's PC-write and PC-source signals. Owns the architectural PC.
// PARAMETERS
//   XLEN       32     width of PC and all address ports
//   RAS_DEPTH  4      return-address stack entries (power of two, >=2)
//   RESET_PC   32'h0  PC value loaded on reset
// PORTS
//   clk            in   1     rising-edge clock
//   reset          in   1     synchronous, active-high reset
//   alu_out        in   XLEN  ALU result this cycle (branch/jump target)
//   alu_out_reg    in   XLEN  registered ALU result (sequential PC, PC+4)
//   bcond          in   1     branch condition true
//   pc_source      in   1     1 = force target path (jump)
//   pc_write       in   1     unconditional PC update
//   pc_write_cond  in   1     PC update only if bcond
//   is_call        in   1     current instr is a call (JAL/JALR with rd=x1/x5)
//   is_ret         in   1     current instr is a return (JALR rs1=x1/x5, rd!=rs1)
//   next_pc        out  XLEN  selected next PC (combinational)
//   current_pc     out  XLEN  architectural PC register
//   ras_top        out  XLEN  predicted return target (top entry; 0 when empty)
//   ras_empty      out  1     stack holds no entries
//   ras_full       out  1     stack holds RAS_DEPTH entries
//   ras_mispredict out  1     one-cycle pulse: popped prediction != actual target
//   ras_overflow   out  1     sticky: push occurred while full
//   ras_underflow  out  1     sticky: pop requested while empty
// BEHAVIOUR
//   - Select: next_pc = alu_out if (pc_source | bcond), else alu_out_reg. Pure comb.
//   - upd = pc_write | (pc_write_cond & bcond). On upd, current_pc <= next_pc at the
//     next rising edge (1-cycle latency); otherwise current_pc holds.
//   - RAS acts only on cycles with upd=1; is_call/is_ret ignored when upd=0.
//   - Push (is_call & !is_ret): write alu_out_reg at top; count++ .
//     Full: circular overwrite of oldest entry, count stays RAS_DEPTH, set ras_overflow.
//   - Pop (is_ret & !is_call): if count>0, compare ras_top with next_pc, count--;
//     ras_mispredict <= (ras_top != next_pc) on the same edge, high exactly one cycle.
//     If empty: no state change, set ras_underflow, ras_mispredict <= 1.
//   - Pop-then-push (is_call & is_ret): top entry replaced by alu_out_reg, count
//     unchanged; mispredict checked as for pop. Empty: acts as push, underflow NOT set.
//   - Pointer arithmetic modulo RAS_DEPTH; count is $clog2(RAS_DEPTH)+1 bits.
//   - ras_top combinational from stored top entry; ras_empty=(count==0),
//     ras_full=(count==RAS_DEPTH).
//   - Reset (any cycle, including mid-update; dominates all inputs): current_pc=RESET_PC,
//     count=0, pointer=0, ras_mispredict=0, ras_overflow=0, ras_underflow=0, ras_top=0,
//     ras_empty=1, ras_full=0. Entry storage need not be cleared.
//   - Sticky flags clear only on reset.
// TESTING
//   1 reset, alu_out=0x40, alu_out_reg=0x04, pc_write=1, no bcond/pc_source -> after
//     1 edge current_pc=0x04; with pc_source=1 -> current_pc=0x40.
//   2 pc_write=0, pc_write_cond=1, bcond=0 -> PC holds; bcond=1, alu_out=0x80 ->
//     current_pc=0x80 next cycle.
//   3 call pushes 0x10,0x20; ret with next_pc=0x20 -> ras_mispredict=0, ras_top=0x10;
//     ret with next_pc=0x14 -> ras_mispredict=1 for one cycle, ras_empty=1.
//   4 RAS_DEPTH=4: push 0x1..0x5 -> ras_full=1, ras_overflow=1, pops return
//     0x5,0x4,0x3,0x2 then empty; 5th pop -> ras_underflow=1, count stays 0.
//   5 is_call&is_ret with stack [0x10,0x20], alu_out_reg=0x30 -> top=0x30, count=2;
//     is_call with pc_write=0 -> no push.
//   6 assert reset during a push cycle -> next cycle current_pc=RESET_PC, ras_empty=1,
//     all flags 0.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
// Architectural PC register, next-PC selection and a return-address stack
// that predicts JALR return targets for the multicycle core.
module pc_redirect_unit #(
   parameter int              XLEN      = 32,
   parameter int              RAS_DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC  = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] alu_out,
   input  logic [XLEN-1:0] alu_out_reg,
   input  logic            bcond,
   input  logic            pc_source,
   input  logic            pc_write,
   input  logic            pc_write_cond,
   input  logic            is_call,
   input  logic            is_ret,
   output logic [XLEN-1:0] next_pc,
   output logic [XLEN-1:0] current_pc,
   output logic [XLEN-1:0] ras_top,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            ras_mispredict,
   output logic            ras_overflow,
   output logic            ras_underflow
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

   // ptr is the next free slot; the top entry lives one below it (mod depth).
   // When the stack is full, ptr also addresses the oldest entry, so a push
   // writing at ptr naturally overwrites the oldest one.
   logic [XLEN-1:0]  entries [RAS_DEPTH];
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] top_idx;
   logic [CNT_W-1:0] count;

   logic upd;
   logic do_push;
   logic do_pop;
   logic do_swap;
   logic swap_as_push;
   logic pred_miss;

   assign next_pc = (pc_source | bcond) ? alu_out : alu_out_reg;
   assign upd     = pc_write | (pc_write_cond & bcond);

   assign top_idx   = ptr - PTR_ONE;
   assign ras_empty = (count == '0);
   assign ras_full  = (count == CNT_MAX);
   assign ras_top   = ras_empty ? '0 : entries[top_idx];

   // The stack only reacts on cycles where the PC is actually updated.
   assign do_push      = upd & is_call & ~is_ret;
   assign do_pop       = upd & is_ret & ~is_call;
   assign do_swap      = upd & is_call & is_ret;
   assign swap_as_push = do_swap & ras_empty;
   assign pred_miss    = (ras_top != next_pc);

   // Architectural PC: load the selected target whenever an update is requested.
   always_ff @(posedge clk) begin
      if (reset) begin
         current_pc <= RESET_PC;
      end else if (upd) begin
         current_pc <= next_pc;
      end
   end

   // Stack bookkeeping: pointer, occupancy, one-cycle mispredict and sticky error flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr            <= '0;
         count          <= '0;
         ras_mispredict <= 1'b0;
         ras_overflow   <= 1'b0;
         ras_underflow  <= 1'b0;
      end else begin
         ras_mispredict <= 1'b0;
         if (do_push || swap_as_push) begin
            ptr <= ptr + PTR_ONE;
            if (ras_full) begin
               ras_overflow <= 1'b1;
            end else begin
               count <= count + CNT_ONE;
            end
         end else if (do_pop) begin
            if (ras_empty) begin
               ras_underflow  <= 1'b1;
               ras_mispredict <= 1'b1;
            end else begin
               ptr            <= top_idx;
               count          <= count - CNT_ONE;
               ras_mispredict <= pred_miss;
            end
         end else if (do_swap) begin
            ras_mispredict <= pred_miss;
         end
      end
   end

   // Entry storage: pushes write the free slot, pop-then-push rewrites the top in place.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (do_push || swap_as_push) begin
            entries[ptr] <= alu_out_reg;
         end else if (do_swap) begin
            entries[top_idx] <= alu_out_reg;
         end
      end
   end

endmodule
